// File: rtl/dual_port_mem_ctrl.sv
// Unified instruction/data RAM controller: a sub-word data port with split misaligned
// accesses and store protection, plus a fully pipelined instruction fetch port.
module dual_port_mem_ctrl #(
  parameter int                ADDR_W         = 16,
  parameter int                MEM_WORDS      = 16384,
  parameter logic [ADDR_W-1:0] WRITABLE_LIMIT = ADDR_W'('h8000),
  parameter int                READ_LATENCY   = 1,
  parameter string             INIT_FILE      = ""
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              d_req,
  input  logic              d_write,
  input  logic              d_size,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [15:0]       d_wdata,
  output logic [15:0]       d_rdata,
  output logic              d_done,
  output logic              d_err,
  output logic              d_busy,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [15:0]       i_rdata,
  output logic              i_done
);
  localparam int WORD_AW = $clog2(MEM_WORDS);
  localparam bit LAT2    = (READ_LATENCY == 2);

  typedef logic [WORD_AW-1:0] widx_t;
  typedef enum logic [2:0] {D_IDLE, D_RD, D_RD2, D_WR2, D_DONE} d_state_t;

  // MEM_WORDS is a power of two, so truncation gives the modulo wrap.
  function automatic widx_t word_idx(input logic [ADDR_W-1:0] a);
    return widx_t'(a >> 1);
  endfunction

  function automatic logic [15:0] fmt_load(input logic [15:0] w, input logic a0,
                                           input logic sz, input logic mis,
                                           input logic [7:0] lo);
    if (mis) return {w[7:0], lo};
    if (sz)  return w;
    return {8'h00, (a0 ? w[15:8] : w[7:0])};
  endfunction

  logic [15:0]       mem [MEM_WORDS];
  d_state_t          state, state_nxt;
  widx_t             ram_addr_a;
  logic [1:0]        ram_we_a;
  logic [15:0]       ram_wd_a;
  logic [15:0]       ram_q_p0, ram_q_p1, ram_q;
  logic [15:0]       i_q_p0, i_q_p1;
  logic              vld_p0, vld_p1;
  logic [ADDR_W-1:0] d_addr_hi, addr_hi_q;
  logic              d_mis, d_prot, capture_lo;
  logic              a0_q, size_q, mis_q, write_q, err_q;
  logic [7:0]        wdata_hi_q, lo_byte_q;
  logic [15:0]       rdata_q, load_word;

  assign d_addr_hi = d_addr + ADDR_W'(1);
  assign d_mis     = d_size & d_addr[0];
  assign d_prot    = (d_addr >= WRITABLE_LIMIT) | (d_size & (d_addr_hi >= WRITABLE_LIMIT));

  always_comb begin
    state_nxt  = state;
    ram_addr_a = word_idx(d_addr);
    ram_we_a   = '0;
    ram_wd_a   = (d_size && !d_addr[0]) ? d_wdata : {2{d_wdata[7:0]}};
    case (state)
      D_IDLE: begin
        if (d_req) begin
          if (d_write) begin
            state_nxt = d_mis ? D_WR2 : D_DONE;
            if (!d_prot) ram_we_a = (d_size && !d_addr[0]) ? 2'b11 : (d_addr[0] ? 2'b10 : 2'b01);
          end else begin
            state_nxt = d_mis ? D_RD2 : (LAT2 ? D_RD : D_DONE);
          end
        end
      end
      D_RD2: begin
        ram_addr_a = word_idx(addr_hi_q);
        state_nxt  = LAT2 ? D_RD : D_DONE;
      end
      D_RD: state_nxt = D_DONE;
      D_WR2: begin
        ram_addr_a = word_idx(addr_hi_q);
        ram_wd_a   = {2{wdata_hi_q}};
        if (!err_q) ram_we_a = 2'b01;
        state_nxt  = D_DONE;
      end
      D_DONE:  state_nxt = D_IDLE;
      default: state_nxt = D_IDLE;
    endcase
    // A split store interrupted by reset keeps only its first byte.
    if (reset) ram_we_a = '0;
  end

  always_ff @(posedge clock) begin
    if (reset) state <= D_IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clock) begin
    if (state == D_IDLE && d_req) begin
      a0_q       <= d_addr[0];
      addr_hi_q  <= d_addr_hi;
      size_q     <= d_size;
      mis_q      <= d_mis;
      write_q    <= d_write;
      err_q      <= d_write & d_prot;
      wdata_hi_q <= d_wdata[15:8];
    end
    if (capture_lo) lo_byte_q <= ram_q[15:8];
  end

  // Stage p0: RAM port A (read-first), p1: optional output register
  always_ff @(posedge clock) begin
    if (ram_we_a[0]) mem[ram_addr_a][7:0]  <= ram_wd_a[7:0];
    if (ram_we_a[1]) mem[ram_addr_a][15:8] <= ram_wd_a[15:8];
    ram_q_p0 <= mem[ram_addr_a];
    ram_q_p1 <= ram_q_p0;
  end

  assign ram_q      = LAT2 ? ram_q_p1 : ram_q_p0;
  assign capture_lo = mis_q && (LAT2 ? (state == D_RD) : (state == D_RD2));
  assign load_word  = fmt_load(ram_q, a0_q, size_q, mis_q, lo_byte_q);

  always_ff @(posedge clock) begin
    if (reset)                           rdata_q <= '0;
    else if (state == D_DONE && !write_q) rdata_q <= load_word;
  end

  assign d_done  = (state == D_DONE);
  assign d_err   = d_done & err_q;
  assign d_busy  = (state != D_IDLE);
  assign d_rdata = (d_done && !write_q) ? load_word : rdata_q;

  // Stage p0: RAM port B fetch, p1: optional output register
  always_ff @(posedge clock) begin
    i_q_p0 <= mem[word_idx(i_addr)];
    i_q_p1 <= i_q_p0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p0 <= i_req;
      vld_p1 <= vld_p0;
    end
  end

  assign i_done  = LAT2 ? vld_p1 : vld_p0;
  assign i_rdata = i_done ? (LAT2 ? i_q_p1 : i_q_p0) : '0;
endmodule

// File: tb/tb_dual_port_mem_ctrl.sv
// Directed bench for dual_port_mem_ctrl: one instance with read latency 1, one with 2,
// sharing everything except the data request line.
module tb_dual_port_mem_ctrl;
  logic        clock = 1'b0;
  logic        reset;
  logic        d_req1, d_req2, d_write, d_size, i_req;
  logic [15:0] d_addr, d_wdata, i_addr;
  logic [15:0] d_rdata1, d_rdata2, i_rdata1, i_rdata2;
  logic        d_done1, d_done2, d_err1, d_err2, d_busy1, d_busy2, i_done1, i_done2;

  always #5 clock = ~clock;

  dual_port_mem_ctrl #(.READ_LATENCY(1)) u1 (
    .clock(clock), .reset(reset), .d_req(d_req1), .d_write(d_write), .d_size(d_size),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata1), .d_done(d_done1),
    .d_err(d_err1), .d_busy(d_busy1), .i_req(i_req), .i_addr(i_addr),
    .i_rdata(i_rdata1), .i_done(i_done1)
  );

  dual_port_mem_ctrl #(.READ_LATENCY(2)) u2 (
    .clock(clock), .reset(reset), .d_req(d_req2), .d_write(d_write), .d_size(d_size),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata2), .d_done(d_done2),
    .d_err(d_err2), .d_busy(d_busy2), .i_req(i_req), .i_addr(i_addr),
    .i_rdata(i_rdata2), .i_done(i_done2)
  );

  typedef struct {
    logic        wr;
    logic        sz;
    logic [15:0] addr;
    logic [15:0] wd;
    int          lat;
    logic [15:0] rd;
    logic        err;
  } vec_t;

  localparam int NV = 26;
  vec_t        vt [NV];
  logic [15:0] w [8];
  int          n_vec = 0;
  int          n_miss = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // which: 1 = u1 only, 2 = u2 only, 3 = both (u1 observed)
  task automatic access(input int which, input logic wr, input logic sz, input logic [15:0] a,
                        input logic [15:0] wd, input int exp_lat, input logic [15:0] exp_rd,
                        input logic exp_err, input string name);
    int          lat;
    logic        done;
    logic        err;
    logic [15:0] rd;
    @(posedge clock); #1;
    d_write = wr; d_size = sz; d_addr = a; d_wdata = wd;
    d_req1 = (which != 2);
    d_req2 = (which != 1);
    lat = 0;
    done = 1'b0;
    while (!done && lat < 8) begin
      @(posedge clock); #1;
      lat++;
      done = (which == 2) ? d_done2 : d_done1;
    end
    err = (which == 2) ? d_err2 : d_err1;
    rd  = (which == 2) ? d_rdata2 : d_rdata1;
    d_req1 = 1'b0;
    d_req2 = 1'b0;
    check({name, " latency"}, 64'(lat), 64'(exp_lat));
    check({name, " err"}, 64'(err), 64'(exp_err));
    if (!wr) check({name, " rdata"}, 64'(rd), 64'(exp_rd));
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " u1 outputs"}, 64'({d_rdata1, i_rdata1, d_done1, d_err1, d_busy1, i_done1}), 64'(0));
    check({tag, " u2 outputs"}, 64'({d_rdata2, i_rdata2, d_done2, d_err2, d_busy2, i_done2}), 64'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected summary");
    $fatal(1);
  end

  initial begin
    logic [5:0]  pat;
    logic [15:0] exp_w;

    // reset held with both ports requesting
    reset = 1'b1; d_req1 = 1'b1; d_req2 = 1'b1; d_write = 1'b1; d_size = 1'b1;
    d_addr = 16'h0302; d_wdata = 16'hDEAD; i_req = 1'b1; i_addr = 16'h0000;
    repeat (3) @(posedge clock);
    #1;
    check_idle_outputs("reset");
    reset = 1'b0; d_req1 = 1'b0; d_req2 = 1'b0; i_req = 1'b0;

    //          wr    sz    addr      wdata     lat rdata     err
    vt[0]  = '{1'b1, 1'b0, 16'h0101, 16'h00AB, 1, 16'h0000, 1'b0};
    vt[1]  = '{1'b1, 1'b0, 16'h0100, 16'h00CD, 1, 16'h0000, 1'b0};
    vt[2]  = '{1'b0, 1'b1, 16'h0100, 16'h0000, 1, 16'hABCD, 1'b0};
    vt[3]  = '{1'b0, 1'b0, 16'h0101, 16'h0000, 1, 16'h00AB, 1'b0};
    vt[4]  = '{1'b0, 1'b0, 16'h0100, 16'h0000, 1, 16'h00CD, 1'b0};
    vt[5]  = '{1'b1, 1'b1, 16'h0202, 16'h5566, 1, 16'h0000, 1'b0};
    vt[6]  = '{1'b1, 1'b1, 16'h0204, 16'h7788, 1, 16'h0000, 1'b0};
    vt[7]  = '{1'b1, 1'b1, 16'h0203, 16'h1234, 2, 16'h0000, 1'b0};
    vt[8]  = '{1'b0, 1'b1, 16'h0203, 16'h0000, 2, 16'h1234, 1'b0};
    vt[9]  = '{1'b0, 1'b0, 16'h0202, 16'h0000, 1, 16'h0066, 1'b0};
    vt[10] = '{1'b0, 1'b0, 16'h0205, 16'h0000, 1, 16'h0077, 1'b0};
    vt[11] = '{1'b0, 1'b1, 16'h0202, 16'h0000, 1, 16'h3466, 1'b0};
    vt[12] = '{1'b0, 1'b1, 16'h0204, 16'h0000, 1, 16'h7712, 1'b0};
    vt[13] = '{1'b1, 1'b1, 16'h0000, 16'h2211, 1, 16'h0000, 1'b0};
    vt[14] = '{1'b1, 1'b0, 16'h8000, 16'h00FF, 1, 16'h0000, 1'b1};
    vt[15] = '{1'b0, 1'b0, 16'h8000, 16'h0000, 1, 16'h0011, 1'b0};
    vt[16] = '{1'b0, 1'b1, 16'h8000, 16'h0000, 1, 16'h2211, 1'b0};
    vt[17] = '{1'b1, 1'b0, 16'h7FFF, 16'h005A, 1, 16'h0000, 1'b0};
    vt[18] = '{1'b1, 1'b1, 16'h7FFF, 16'hBEEF, 2, 16'h0000, 1'b1};
    vt[19] = '{1'b0, 1'b0, 16'h7FFF, 16'h0000, 1, 16'h005A, 1'b0};
    vt[20] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1, 16'h0011, 1'b0};
    vt[21] = '{1'b0, 1'b1, 16'hFFFF, 16'h0000, 2, 16'h115A, 1'b0};
    vt[22] = '{1'b1, 1'b1, 16'hFFFF, 16'h9999, 2, 16'h0000, 1'b1};
    vt[23] = '{1'b0, 1'b1, 16'h0000, 16'h0000, 1, 16'h2211, 1'b0};
    vt[24] = '{1'b1, 1'b1, 16'h0300, 16'h1111, 1, 16'h0000, 1'b0};
    vt[25] = '{1'b1, 1'b1, 16'h0302, 16'h3333, 1, 16'h0000, 1'b0};

    for (int i = 0; i < NV; i++)
      access(1, vt[i].wr, vt[i].sz, vt[i].addr, vt[i].wd, vt[i].lat, vt[i].rd, vt[i].err,
             $sformatf("vec%0d", i));

    // back-to-back aligned byte stores with d_req held: done every other cycle
    @(posedge clock); #1;
    d_write = 1'b1; d_size = 1'b0; d_addr = 16'h0400; d_wdata = 16'h0077; d_req1 = 1'b1;
    pat = '0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clock); #1;
      pat[k] = d_done1;
    end
    d_req1 = 1'b0;
    check("b2b done pattern", 64'(pat), 64'(6'b010101));
    access(1, 1'b0, 1'b0, 16'h0400, 16'h0000, 1, 16'h0077, 1'b0, "b2b readback");

    // reset between the halves of a split store
    @(posedge clock); #1;
    d_write = 1'b1; d_size = 1'b1; d_addr = 16'h0301; d_wdata = 16'hA1B2; d_req1 = 1'b1;
    @(posedge clock); #1;
    reset = 1'b1; d_req1 = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    check("split reset busy", 64'(d_busy1), 64'(0));
    access(1, 1'b0, 1'b1, 16'h0300, 16'h0000, 1, 16'hB211, 1'b0, "split reset first byte");
    access(1, 1'b0, 1'b1, 16'h0302, 16'h0000, 1, 16'h3333, 1'b0, "split reset second byte");

    // reset with a store held on both instances must not write
    @(posedge clock); #1;
    reset = 1'b1; d_req1 = 1'b1; d_req2 = 1'b1; d_write = 1'b1; d_size = 1'b1;
    d_addr = 16'h0302; d_wdata = 16'hDEAD; i_req = 1'b1; i_addr = 16'h0002;
    repeat (3) @(posedge clock);
    #1;
    check_idle_outputs("reset2");
    reset = 1'b0; d_req1 = 1'b0; d_req2 = 1'b0; i_req = 1'b0;
    access(1, 1'b0, 1'b1, 16'h0302, 16'h0000, 1, 16'h3333, 1'b0, "reset no write");

    // fetch stream on both latencies
    for (int k = 0; k < 8; k++) begin
      w[k] = 16'h1000 + 16'(k) * 16'h0101;
      access(3, 1'b1, 1'b1, 16'(2 * k), w[k], 1, 16'h0000, 1'b0, $sformatf("preload%0d", k));
    end
    for (int t = 0; t < 10; t++) begin
      i_req  = (t < 8);
      i_addr = (t < 8) ? 16'(2 * t) : 16'h0000;
      @(posedge clock); #1;
      check($sformatf("fetch L1 done t%0d", t), 64'(i_done1), 64'(t < 8));
      if (t < 8) check($sformatf("fetch L1 data t%0d", t), 64'(i_rdata1), 64'(w[t]));
      check($sformatf("fetch L2 done t%0d", t), 64'(i_done2), 64'(t >= 1 && t < 9));
      if (t >= 1 && t < 9) check($sformatf("fetch L2 data t%0d", t), 64'(i_rdata2), 64'(w[t-1]));
    end
    i_req = 1'b0;

    // collision: store word 5 while fetching it
    @(posedge clock); #1;
    d_write = 1'b1; d_size = 1'b1; d_addr = 16'h000A; d_wdata = 16'hC0DE; d_req1 = 1'b1;
    i_req = 1'b1; i_addr = 16'h000A;
    @(posedge clock); #1;
    check("collision store done", 64'(d_done1), 64'(1));
    check("collision fetch done", 64'(i_done1), 64'(1));
    check("collision old data", 64'(i_rdata1), 64'(w[5]));
    d_req1 = 1'b0;
    @(posedge clock); #1;
    check("collision new data", 64'(i_rdata1), 64'(16'hC0DE));
    i_req = 1'b0;

    // data port with read latency 2
    access(2, 1'b0, 1'b1, 16'h0004, 16'h0000, 2, w[2], 1'b0, "L2 aligned load");
    exp_w = {w[2][7:0], w[1][15:8]};
    access(2, 1'b0, 1'b1, 16'h0003, 16'h0000, 3, exp_w, 1'b0, "L2 split load");
    exp_w = {8'h00, w[2][15:8]};
    access(2, 1'b0, 1'b0, 16'h0005, 16'h0000, 2, exp_w, 1'b0, "L2 byte load");
    access(2, 1'b1, 1'b0, 16'h0006, 16'h00EE, 1, 16'h0000, 1'b0, "L2 byte store");
    access(2, 1'b0, 1'b0, 16'h0006, 16'h0000, 2, 16'h00EE, 1'b0, "L2 byte readback");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
